// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and the spi_slave users on the same FPGA.
package spi_pkg;

    localparam int SPI_WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period counter for the SPI master: owns the sck level and flags the
// cycle on which sck will rise or fall at the next CLOCK_50 edge.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic en,
    input  logic sck_en,
    output logic sck,
    output logic tc,
    output logic rise,
    output logic fall
);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_sck_gen: CLK_DIV must be at least 2");
    end

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tc   = en && (cnt == CNT_TC);
    assign rise = tc && sck_en && !sck;
    assign fall = tc && sck_en && sck;

    // Counter free-runs while enabled, so every phase lasts exactly CLK_DIV cycles.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + CW'(1);
            if (tc && sck_en) begin
                sck <= ~sck;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, full duplex, one DATA_W-bit word per frame.
//   state | meaning
//   IDLE  | waiting for start, cs_n high, sck low
//   LEAD  | cs_n low, mosi setup before the first sck rise
//   HIGH  | sck high; miso captured on the edge entering this state
//   LOW   | sck low between bits; mosi already moved to the next bit
//   TRAIL | sck low, cs_n still low after the last bit
//   GAP   | cs_n high, busy still high, minimum deselect time
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_WORD_W,
    parameter int CLK_DIV = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    spi_state_t state, state_nxt;

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic              busy_d;
    logic              en, sck_en, tc, rise, fall;
    logic              last_bit, accept;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .en       (en),
        .sck_en   (sck_en),
        .sck      (sck),
        .tc       (tc),
        .rise     (rise),
        .fall     (fall)
    );

    assign last_bit = (bit_cnt == LAST_BIT);
    // busy_d blocks a start seen in the very cycle busy drops.
    assign accept   = (state == IDLE) && start && !busy_d;
    assign en       = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sck_en    = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = LEAD;
            LEAD:  begin
                sck_en = 1'b1;
                if (rise) state_nxt = HIGH;
            end
            HIGH:  begin
                sck_en = 1'b1;
                if (fall) state_nxt = last_bit ? TRAIL : LOW;
            end
            LOW:   begin
                sck_en = 1'b1;
                if (rise) state_nxt = HIGH;
            end
            TRAIL: if (tc) state_nxt = GAP;
            GAP:   if (tc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            busy_d  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done   <= 1'b0;
            busy_d <= busy;
            case (state)
                IDLE: if (accept) begin
                    tx_sr   <= tx_data;
                    mosi    <= tx_data[DATA_W-1];
                    cs_n    <= 1'b0;
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                end
                LEAD, LOW: if (rise) begin
                    rx_sr <= {rx_sr[DATA_W-2:0], miso};
                end
                HIGH: if (fall && !last_bit) begin
                    tx_sr   <= tx_sr << 1;
                    mosi    <= tx_sr[DATA_W-2];
                    bit_cnt <= bit_cnt + BW'(1);
                end
                TRAIL: if (tc) begin
                    cs_n    <= 1'b1;
                    mosi    <= 1'b0;
                    rx_data <= rx_sr;
                    done    <= 1'b1;
                end
                GAP: if (tc) begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed/randomized bench for spi_master: loopback, behavioural slave, ignored start,
// reset mid-frame and back-to-back frames, checked against frame timing arithmetic.
module tb_spi_master;

    localparam int W  = 32;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic          busy, done, sck, mosi, miso, cs_n;
    logic [W-1:0]  rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    spi_master #(.DATA_W(W), .CLK_DIV(CD)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .tx_data  (tx_data),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    always #5 clk = ~clk;

    // Behavioural mode-0 slave: loads on cs_n fall, shifts out on sck fall, samples on sck rise.
    logic         loop = 1'b1;
    logic [W-1:0] s_d = '0, s_sr = '0, s_rx = '0, s_q = '0;
    int           n_sck_rise = 0;

    assign miso = loop ? mosi : s_sr[W-1];

    always @(negedge cs_n) s_sr = s_d;
    always @(negedge sck) if (!cs_n) s_sr = s_sr << 1;
    always @(posedge sck) begin
        n_sck_rise++;
        if (!cs_n) s_rx = {s_rx[W-2:0], mosi};
    end
    always @(posedge cs_n) s_q = s_rx;

    int           f_cs_fall, f_cs_rise, f_first_rise, f_rises, f_rise_err, f_mosi_err;
    int           f_done_cnt, f_done_c, f_busy_fall;
    logic [W-1:0] f_rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame and logs its events; cycle c is the interval after the c-th edge
    // following the start request. lag shifts expectations when start is already held.
    task automatic run_frame(input logic [W-1:0] tx, input bit hold, input int lag,
                             input int stray_at, input int reset_at);
        bit   prev_sck = 1'b0;
        bit   seen_busy = 1'b0;
        f_cs_fall = -1; f_cs_rise = -1; f_first_rise = -1; f_rises = 0;
        f_rise_err = 0; f_mosi_err = 0; f_done_cnt = 0; f_done_c = -1;
        f_busy_fall = -1; f_rx = '0;
        tx_data = tx;
        start   = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !hold) start = 1'b0;
            if (busy) seen_busy = 1'b1;
            if (cs_n == 1'b0 && f_cs_fall < 0) f_cs_fall = c;
            if (cs_n == 1'b1 && f_cs_fall >= 0 && f_cs_rise < 0) f_cs_rise = c;
            if (sck && !prev_sck) begin
                if (f_first_rise < 0) f_first_rise = c;
                if (c != lag + 1 + CD + 2 * f_rises * CD) f_rise_err++;
                if (f_rises < W && mosi !== tx[W-1-f_rises]) f_mosi_err++;
                f_rises++;
            end
            prev_sck = sck;
            if (done) begin
                f_done_cnt++;
                f_done_c = c;
                f_rx = rx_data;
            end
            if (c == stray_at) begin
                tx_data = 32'hFFFF_FFFF;
                start   = 1'b1;
            end
            if (c == stray_at + 1) start = 1'b0;
            if (c == reset_at) begin
                #1 reset = 1'b0;
                #1;
                check("midrst_cs_n_now", 32'(cs_n), 32'd1);
                check("midrst_sck_now", 32'(sck), 32'd0);
            end
            if (seen_busy && !busy) begin
                f_busy_fall = c;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [W-1:0] exp_rx, input int lag);
        check({tag, "_cs_fall"},    32'(f_cs_fall),    32'(lag + 1));
        check({tag, "_first_rise"}, 32'(f_first_rise), 32'(lag + 1 + CD));
        check({tag, "_rises"},      32'(f_rises),      32'(W));
        check({tag, "_rise_times"}, 32'(f_rise_err),   32'd0);
        check({tag, "_mosi_bits"},  32'(f_mosi_err),   32'd0);
        check({tag, "_done_cnt"},   32'(f_done_cnt),   32'd1);
        check({tag, "_done_c"},     32'(f_done_c),     32'(lag + 1 + (2 * W + 1) * CD));
        check({tag, "_cs_rise"},    32'(f_cs_rise),    32'(lag + 1 + (2 * W + 1) * CD));
        check({tag, "_rx"},         f_rx,              exp_rx);
        check({tag, "_busy_fall"},  32'(f_busy_fall),  32'(lag + 1 + (2 * W + 2) * CD));
    endtask

    initial begin
        logic [W-1:0] tx, d;
        int           sck0, b1_cs_rise, b1_busy_fall, b1_done;

        // Reset and idle
        tick(3);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", rx_data, 32'h0);
        reset = 1'b1;
        sck0 = n_sck_rise;
        tick(20);
        check("idle_no_sck", 32'(n_sck_rise - sck0), 32'd0);
        check("idle_cs_n", 32'(cs_n), 32'd1);

        // Loopback with a start pulse during the frame that must be ignored
        loop = 1'b1;
        run_frame(32'hA5C3_0F1E, 1'b0, 0, 100, -1);
        check_frame("loop", 32'hA5C3_0F1E, 0);
        tick(5);
        check("loop_rx_held", rx_data, 32'hA5C3_0F1E);
        check("loop_idle_busy", 32'(busy), 32'd0);

        // Randomized loopback frames
        for (int i = 0; i < 3; i++) begin
            tx = $urandom;
            run_frame(tx, 1'b0, 0, -1, -1);
            check_frame("rand_loop", tx, 0);
            tick(3);
        end

        // Against the behavioural slave
        loop = 1'b0;
        s_d  = 32'h1234_5678;
        run_frame(32'hCAFE_BABE, 1'b0, 0, -1, -1);
        check_frame("slave", 32'h1234_5678, 0);
        check("slave_q", s_q, 32'hCAFE_BABE);
        tick(3);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            tx = $urandom;
            s_d = d;
            run_frame(tx, 1'b0, 0, -1, -1);
            check_frame("rand_slave", d, 0);
            check("rand_slave_q", s_q, tx);
            tick(3);
        end
        loop = 1'b1;

        // Reset mid-transfer, then a full frame after release
        run_frame(32'h5A5A_F00F, 1'b0, 0, -1, 120);
        check("midrst_no_done", 32'(f_done_cnt), 32'd0);
        check("midrst_rx", rx_data, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(2);
        tx = $urandom;
        run_frame(tx, 1'b0, 0, -1, -1);
        check_frame("post_rst", tx, 0);
        tick(3);

        // Back-to-back with start held high
        tx = $urandom;
        run_frame(tx, 1'b1, 0, -1, -1);
        check_frame("b2b1", tx, 0);
        b1_cs_rise   = f_cs_rise;
        b1_busy_fall = f_busy_fall;
        b1_done      = f_done_cnt;
        tx = $urandom;
        run_frame(tx, 1'b1, 1, -1, -1);
        start = 1'b0;
        check_frame("b2b2", tx, 1);
        check("b2b_second_cs_fall", 32'(b1_busy_fall + f_cs_fall), 32'(1 + (2 * W + 2) * CD + 2));
        check("b2b_cs_high_min", 32'((b1_busy_fall + f_cs_fall - b1_cs_rise) >= CD + 1), 32'd1);
        check("b2b_one_done_each", 32'(b1_done + f_done_cnt), 32'd2);
        tick(CD * 4);
        check("b2b_stopped", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
